// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: asserts all channel resets asynchronously and releases them
// synchronously in a staggered order; a software request re-runs the sequence on a channel subset.
module rst_seq_gen #(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int RST_CLK_CYCLES = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sw_rst_req_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic [NUM_CH-1:0] rst_no,
  output logic              done_o,
  output logic              sw_rst_ack_o,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_MAX = RST_CLK_CYCLES + (NUM_CH - 1) * STAGGER_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e                  r_state;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic [CW-1:0]           r_cnt;
  logic [NUM_CH-1:0]       r_rst;
  logic [NUM_CH-1:0]       r_mask;
  logic                    r_done;
  logic                    r_ack;
  logic                    r_sw;

  logic [CW-1:0]           w_v;
  logic [CW-1:0]           w_last_thr;
  logic [NUM_CH-1:0]       w_release;
  logic                    w_step;
  logic                    w_finish;
  logic                    w_accept;
  logic                    w_sync_done;

  // Counter value at which channel idx is released, measured from the first sequencing edge.
  function automatic logic [CW-1:0] thr(input int idx);
    return CW'(RST_CLK_CYCLES - 1 + idx * STAGGER_CYCLES);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign w_sync_done = r_sync[SYNC_STAGES-1];

  // The SYNC->HOLD edge already counts as sequencing step 0, so a one-cycle hold is reachable.
  always_comb begin
    w_v        = (r_state == ST_HOLD) ? r_cnt : '0;
    w_step     = (r_state == ST_HOLD) || ((r_state == ST_SYNC) && w_sync_done);
    w_last_thr = '0;
    w_release  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_mask[i]) w_last_thr = thr(i);
      w_release[i] = (w_v >= thr(i));
    end
    w_finish = w_step && (w_v == w_last_thr);
    w_accept = (r_state == ST_RUN) && sw_rst_req_i && (|ch_mask_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_SYNC;
      r_cnt   <= '0;
      r_rst   <= '1;
      r_mask  <= '1;
      r_done  <= 1'b0;
      r_ack   <= 1'b0;
      r_sw    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (w_step) begin
        r_rst <= r_rst & ~w_release;
        if (w_finish) begin
          r_state <= ST_RUN;
          r_done  <= 1'b1;
          r_ack   <= r_sw;
          r_sw    <= 1'b0;
        end else begin
          r_state <= ST_HOLD;
          if (w_v != CW'(CNT_MAX)) r_cnt <= w_v + CW'(1);
        end
      end else if (w_accept) begin
        r_state <= ST_HOLD;
        r_rst   <= r_rst | ch_mask_i;
        r_mask  <= ch_mask_i;
        r_cnt   <= '0;
        r_done  <= 1'b0;
        r_sw    <= 1'b1;
      end
    end
  end

  assign rst_o        = r_rst;
  assign rst_no       = ~r_rst;
  assign done_o       = r_done;
  assign sw_rst_ack_o = r_ack;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: default four-channel instance against an edge-schedule model,
// plus a single-channel minimal-timing instance checked against fixed edge numbers.
module tb_rst_seq_gen;

  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int RC  = 16;
  localparam int SC  = 4;

  logic           clk = 1'b0;
  logic           rst_ni, sw_req;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] rst_o, rst_no;
  logic           done_o, ack_o;
  logic [1:0]     dbg;

  logic           rst2_ni, sw2_req;
  logic [0:0]     mask2, rst2_o, rst2_no;
  logic           done2, ack2;
  logic [1:0]     dbg2;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Model: absolute edge at which each channel leaves reset, plus done/ack edges.
  int rel[NCH];
  int done_at, ack_at, pon_base;
  bit in_reset;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  rst_seq_gen #(.NUM_CH(NCH), .SYNC_STAGES(SS), .RST_CLK_CYCLES(RC), .STAGGER_CYCLES(SC)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .sw_rst_req_i(sw_req), .ch_mask_i(mask),
    .rst_o(rst_o), .rst_no(rst_no), .done_o(done_o), .sw_rst_ack_o(ack_o), .dbg_state_o(dbg)
  );

  rst_seq_gen #(.NUM_CH(1), .SYNC_STAGES(3), .RST_CLK_CYCLES(1), .STAGGER_CYCLES(0)) u_dut2 (
    .clk_i(clk), .rst_ni(rst2_ni), .sw_rst_req_i(sw2_req), .ch_mask_i(mask2),
    .rst_o(rst2_o), .rst_no(rst2_no), .done_o(done2), .sw_rst_ack_o(ack2), .dbg_state_o(dbg2)
  );

  function automatic logic [NCH-1:0] m_rst(input int c);
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = in_reset ? 1'b1 : (c < rel[i]);
    return r;
  endfunction

  function automatic logic m_done(input int c);
    return !in_reset && (c >= done_at);
  endfunction

  function automatic logic m_ack(input int c);
    return !in_reset && (c == ack_at);
  endfunction

  // ---------------- driver tasks (called right after a falling edge) ----------------
  task automatic drv_release();
    rst_ni   = 1'b1;
    in_reset = 1'b0;
    pon_base = edge_n;
    for (int i = 0; i < NCH; i++) rel[i] = edge_n + SS + RC + i * SC;
    done_at = rel[NCH-1];
    ack_at  = -1;
  endtask

  task automatic drv_req(input logic [NCH-1:0] m);
    int e, hi;
    sw_req = 1'b1;
    mask   = m;
    e      = edge_n + 1;
    if (!in_reset && (e - 1 >= done_at) && (m != '0)) begin
      hi = 0;
      for (int i = 0; i < NCH; i++) begin
        if (m[i]) begin
          rel[i] = e + RC + i * SC;
          hi     = i;
        end
      end
      done_at = e + RC + hi * SC;
      ack_at  = done_at;
    end
  endtask

  task automatic drv_assert_rst();
    #2;
    rst_ni   = 1'b0;
    sw_req   = 1'b0;
    in_reset = 1'b1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_ni = 1'b1; sw_req = 1'b0; mask = '0;
    rst2_ni = 1'b0; sw2_req = 1'b0; mask2 = '0;
    #1 rst_ni = 1'b0;
    in_reset = 1'b1;
    done_at  = 0;
    ack_at   = -1;
    #1;
    n_checks++; if (rst_o !== 4'hF) begin n_fail++; $display("FAIL reset_rst_o: got %h want f", rst_o); end
    n_checks++; if (rst_no !== 4'h0) begin n_fail++; $display("FAIL reset_rst_no: got %h want 0", rst_no); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack_o); end
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (rst_o !== 4'hF) begin n_fail++; $display("FAIL reset_hold: got %h want f", rst_o); end
    end
  endtask

  task automatic test_power_on();
    int fall[NCH];
    int exp_fall[NCH] = '{18, 22, 26, 30};
    for (int i = 0; i < NCH; i++) fall[i] = -1;
    drv_release();
    repeat (34) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) if (fall[i] < 0 && rst_o[i] === 1'b0) fall[i] = edge_n - pon_base;
      n_checks++; if (rst_o !== m_rst(edge_n)) begin n_fail++; $display("FAIL pon_rst_o: got %h want %h edge %0d", rst_o, m_rst(edge_n), edge_n - pon_base); end
      n_checks++; if (rst_no !== ~m_rst(edge_n)) begin n_fail++; $display("FAIL pon_rst_no: got %h want %h", rst_no, ~m_rst(edge_n)); end
      n_checks++; if (done_o !== m_done(edge_n)) begin n_fail++; $display("FAIL pon_done: got %b want %b edge %0d", done_o, m_done(edge_n), edge_n - pon_base); end
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL pon_ack: got %b want 0", ack_o); end
    end
    for (int i = 0; i < NCH; i++) begin
      n_checks++; if (fall[i] != exp_fall[i]) begin n_fail++; $display("FAIL pon_fall_edge ch%0d: got %0d want %0d", i, fall[i], exp_fall[i]); end
    end
  endtask

  task automatic test_async_reset();
    drv_assert_rst();
    #1;
    n_checks++; if (rst_o !== 4'hF) begin n_fail++; $display("FAIL async_rst_o: got %h want f", rst_o); end
    n_checks++; if (rst_no !== 4'h0) begin n_fail++; $display("FAIL async_rst_no: got %h want 0", rst_no); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL async_done: got %b want 0", done_o); end
    repeat (2) @(negedge clk);
    drv_release();
    repeat (34) begin
      @(negedge clk);
      n_checks++; if (rst_o !== m_rst(edge_n)) begin n_fail++; $display("FAIL async_seq_rst_o: got %h want %h", rst_o, m_rst(edge_n)); end
      n_checks++; if (done_o !== m_done(edge_n)) begin n_fail++; $display("FAIL async_seq_done: got %b want %b", done_o, m_done(edge_n)); end
    end
  endtask

  task automatic test_sw_mask();
    int e;
    e = edge_n + 1;
    drv_req(4'b1010);
    repeat (32) begin
      @(negedge clk);
      sw_req = 1'b0;
      n_checks++; if (rst_o !== m_rst(edge_n)) begin n_fail++; $display("FAIL sw_rst_o: got %h want %h at E+%0d", rst_o, m_rst(edge_n), edge_n - e); end
      n_checks++; if (rst_no !== ~m_rst(edge_n)) begin n_fail++; $display("FAIL sw_rst_no: got %h want %h", rst_no, ~m_rst(edge_n)); end
      n_checks++; if (done_o !== m_done(edge_n)) begin n_fail++; $display("FAIL sw_done: got %b want %b at E+%0d", done_o, m_done(edge_n), edge_n - e); end
      n_checks++; if (ack_o !== (edge_n == e + 28)) begin n_fail++; $display("FAIL sw_ack: got %b want %b at E+%0d", ack_o, edge_n == e + 28, edge_n - e); end
    end
  endtask

  task automatic test_sw_ignored();
    drv_req(4'b0000);
    repeat (3) begin
      @(negedge clk);
      sw_req = 1'b0;
      n_checks++; if ({rst_o, done_o, ack_o} !== 6'b0000_10) begin n_fail++; $display("FAIL zero_mask: got rst %h done %b ack %b want 0/1/0", rst_o, done_o, ack_o); end
    end
    drv_req(4'b0001);
    repeat (5) begin @(negedge clk); sw_req = 1'b0; end
    drv_req(4'b1111);
    repeat (20) begin
      @(negedge clk);
      sw_req = 1'b0;
      n_checks++; if (rst_o !== m_rst(edge_n)) begin n_fail++; $display("FAIL hold_req_rst_o: got %h want %h", rst_o, m_rst(edge_n)); end
      n_checks++; if (done_o !== m_done(edge_n)) begin n_fail++; $display("FAIL hold_req_done: got %b want %b", done_o, m_done(edge_n)); end
      n_checks++; if (ack_o !== m_ack(edge_n)) begin n_fail++; $display("FAIL hold_req_ack: got %b want %b", ack_o, m_ack(edge_n)); end
    end
  endtask

  task automatic test_rst_mid_sw();
    drv_req(4'b1010);
    repeat (9) begin @(negedge clk); sw_req = 1'b0; end
    drv_assert_rst();
    #1;
    n_checks++; if ({rst_o, done_o, ack_o} !== 6'b1111_00) begin n_fail++; $display("FAIL mid_sw_reset: got rst %h done %b ack %b want f/0/0", rst_o, done_o, ack_o); end
    repeat (3) @(negedge clk);
    drv_release();
    repeat (34) begin
      @(negedge clk);
      n_checks++; if (rst_o !== m_rst(edge_n)) begin n_fail++; $display("FAIL mid_sw_rst_o: got %h want %h", rst_o, m_rst(edge_n)); end
      n_checks++; if (done_o !== m_done(edge_n)) begin n_fail++; $display("FAIL mid_sw_done: got %b want %b", done_o, m_done(edge_n)); end
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL mid_sw_ack: got %b want 0", ack_o); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      repeat ($urandom_range(0, 36)) begin
        @(negedge clk);
        sw_req = 1'b0;
        n_checks++; if (rst_o !== m_rst(edge_n)) begin n_fail++; $display("FAIL rand_rst_o: got %h want %h edge %0d", rst_o, m_rst(edge_n), edge_n); end
        n_checks++; if (done_o !== m_done(edge_n)) begin n_fail++; $display("FAIL rand_done: got %b want %b edge %0d", done_o, m_done(edge_n), edge_n); end
        n_checks++; if (ack_o !== m_ack(edge_n)) begin n_fail++; $display("FAIL rand_ack: got %b want %b edge %0d", ack_o, m_ack(edge_n), edge_n); end
      end
      drv_req(4'($urandom_range(0, 15)));
    end
    repeat (32) begin
      @(negedge clk);
      sw_req = 1'b0;
      n_checks++; if (rst_o !== m_rst(edge_n)) begin n_fail++; $display("FAIL rand_tail_rst_o: got %h want %h", rst_o, m_rst(edge_n)); end
      n_checks++; if (ack_o !== m_ack(edge_n)) begin n_fail++; $display("FAIL rand_tail_ack: got %b want %b", ack_o, m_ack(edge_n)); end
    end
  endtask

  task automatic test_small_cfg();
    int b, e;
    @(negedge clk);
    rst2_ni = 1'b1;
    b = edge_n;
    repeat (6) begin
      @(negedge clk);
      n_checks++; if (rst2_o !== 1'((edge_n - b) < 4)) begin n_fail++; $display("FAIL small_pon_rst: got %b edge %0d", rst2_o, edge_n - b); end
      n_checks++; if (rst2_no !== ~rst2_o) begin n_fail++; $display("FAIL small_rst_no: got %b want %b", rst2_no, ~rst2_o); end
      n_checks++; if (done2 !== ((edge_n - b) >= 4)) begin n_fail++; $display("FAIL small_pon_done: got %b edge %0d", done2, edge_n - b); end
    end
    sw2_req = 1'b1;
    mask2   = 1'b1;
    e = edge_n + 1;
    repeat (4) begin
      @(negedge clk);
      sw2_req = 1'b0;
      n_checks++; if (rst2_o !== 1'(edge_n == e)) begin n_fail++; $display("FAIL small_sw_rst: got %b at E+%0d", rst2_o, edge_n - e); end
      n_checks++; if (done2 !== (edge_n != e)) begin n_fail++; $display("FAIL small_sw_done: got %b at E+%0d", done2, edge_n - e); end
      n_checks++; if (ack2 !== (edge_n == e + 1)) begin n_fail++; $display("FAIL small_sw_ack: got %b at E+%0d", ack2, edge_n - e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_on();
    test_async_reset();
    test_sw_mask();
    test_sw_ignored();
    test_rst_mid_sw();
    test_random();
    test_small_cfg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
